program_counter: RTL
====================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge system clock.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-003 SHALL provide: programByte  input  8  ROM data at address pc; low byte of the jump target during execute.
REQ-004 SHALL provide: operand  input  4  latched operand nibble from fetch stage; high nibble of the jump target.
REQ-005 SHALL provide: twoByte  input  1  current instruction carries a target byte (jump/call class).
REQ-006 SHALL provide: jumpTaken  input  1  control: branch condition true (meaningful only with twoByte).
REQ-007 SHALL provide: call  input  1  control: current instruction is a call (needs twoByte).
REQ-008 SHALL provide: ret  input  1  control: current instruction is a return (single-byte).
REQ-009 SHALL provide: halt  input  1  freeze request.
REQ-010 SHALL provide: pc  output  12  ROM address.
REQ-011 SHALL provide: phase  output  1  1 = fetch cycle (fetch stage latches programByte), 0 = execute cycle.
REQ-012 SHALL provide: stackDepth  output  3  return-stack occupancy, 0..4.
REQ-013 SHALL provide: stackErr  output  1  sticky overflow/underflow flag.

Function
REQ-014 phase SHALL toggle every clock unless frozen by halt (REQ-017).
REQ-015 Fetch cycle (phase=1): pc <= pc+1 at the clock edge; control inputs except reset SHALL be ignored.
REQ-016 Execute cycle (phase=0): next pc SHALL be chosen by priority ret > call > jumpTaken > twoByte > none.
REQ-017 halt=1 in execute: pc, phase, stack SHALL hold; halt in fetch ignored, so a halt always freezes at execute.
REQ-018 ret: pc <= popped address; stackDepth-1.
REQ-019 call with twoByte: push pc+1 (address after target byte); pc <= {operand, programByte}; stackDepth+1.
REQ-020 jumpTaken with twoByte: pc <= {operand, programByte}.
REQ-021 twoByte, no jump/call: pc <= pc+1 (skip target byte).
REQ-022 none asserted: pc unchanged (next fetch reads byte at pc).
REQ-023 jumpTaken or call without twoByte SHALL be ignored (treated as none).
REQ-024 pc arithmetic SHALL be modulo 4096: 0xFFF+1 = 0x000, in both fetch and skip.
REQ-025 Push at depth 4: oldest entry discarded, new entry kept, depth stays 4, stackErr set.
REQ-026 Pop at depth 0: treated as none (pc unchanged), depth stays 0, stackErr set.
REQ-027 stackErr SHALL stay 1 until reset.

Reset
REQ-028 reset=1 at a clock edge: pc=0x000, phase=1, stackDepth=0, stackErr=0, stack contents cleared; overrides halt and all control inputs.
REQ-029 reset asserted mid-execute or while halted SHALL abandon the instruction; first post-reset cycle is a fetch at 0x000.

Configuration
REQ-030 Macro PROGRAM_COUNTER_CALL_STACK_EN SHALL compile in the 4-entry return stack.
REQ-031 Defined: REQ-018, REQ-019, REQ-025, REQ-026 apply.
REQ-032 Undefined: call behaves as jumpTaken (no push), ret behaves as none, stackDepth and stackErr tied to 0, no stack storage.

Verification
REQ-033 Reset release, no controls, 6 clocks -> pc 0,1,1,2,2,3 with phase 1,0,1,0,1,0.
REQ-034 Jump: opcode at 0x010, twoByte=1, jumpTaken=1, operand=0xA, programByte=0x5C in execute -> next fetch at pc=0xA5C; with jumpTaken=0 -> next fetch at 0x012.
REQ-035 pc=0xFFF fetch -> pc=0x000 in execute; twoByte skip from 0xFFF -> 0x000.
REQ-036 (_EN defined) Call from 0x020 to 0x300, then ret -> pc=0x300 then fetch resumes at 0x022; 5 nested calls -> depth 4, stackErr=1; ret at depth 0 -> pc holds, stackErr=1.
REQ-037 halt held 3 execute cycles -> pc and phase frozen 3 clocks; reset during halt -> pc=0x000, phase=1 next cycle.
REQ-038 (_EN undefined) Call to 0x300 then ret -> pc=0x300 then next fetch at 0x301; stackDepth=0, stackErr=0 throughout.

Source files
------------

// File: rtl/program_counter_if.sv
// Program counter bus: fetch/execute control inputs and pc/stack status outputs.
// Master drives the control side; slave is the program counter itself.
interface program_counter_if;
    logic [7:0]  programByte;
    logic [3:0]  operand;
    logic        twoByte;
    logic        jumpTaken;
    logic        call;
    logic        ret;
    logic        halt;
    logic [11:0] pc;
    logic        phase;
    logic [2:0]  stackDepth;
    logic        stackErr;

    modport master (
        output programByte,
        output operand,
        output twoByte,
        output jumpTaken,
        output call,
        output ret,
        output halt,
        input  pc,
        input  phase,
        input  stackDepth,
        input  stackErr
    );

    modport slave (
        input  programByte,
        input  operand,
        input  twoByte,
        input  jumpTaken,
        input  call,
        input  ret,
        input  halt,
        output pc,
        output phase,
        output stackDepth,
        output stackErr
    );
endinterface

// File: rtl/program_counter.sv
// Two-phase (fetch/execute) 12-bit program counter with optional return stack.
// Define PROGRAM_COUNTER_CALL_STACK_EN to build in the 4-entry call/return stack.
module program_counter (
    input  logic             clk,
    input  logic             reset,
    program_counter_if.slave bus
);
    typedef enum logic {
        PH_EXEC  = 1'b0,
        PH_FETCH = 1'b1
    } phase_e;

    phase_e      phase_q;
    phase_e      phase_d;
    logic [11:0] pc_q;
    logic [11:0] pc_d;
    logic [11:0] pc_inc;
    logic [11:0] target;

    assign pc_inc = pc_q + 12'd1;
    assign target = {bus.operand, bus.programByte};

`ifdef PROGRAM_COUNTER_CALL_STACK_EN
    logic [11:0] stk_q [4];
    logic [11:0] stk_d [4];
    logic [2:0]  depth_q;
    logic [2:0]  depth_d;
    logic        err_q;
    logic        err_d;
    logic [1:0]  top_idx;

    // depth 4 wraps the low bits to 0, so top-1 still lands on entry 3
    assign top_idx = depth_q[1:0] - 2'd1;

    always_comb begin
        pc_d    = pc_q;
        phase_d = phase_q;
        stk_d   = stk_q;
        depth_d = depth_q;
        err_d   = err_q;
        unique case (phase_q)
            PH_FETCH: begin
                pc_d    = pc_inc;
                phase_d = PH_EXEC;
            end
            PH_EXEC: begin
                if (!bus.halt) begin
                    phase_d = PH_FETCH;
                    if (bus.ret) begin
                        if (depth_q != 3'd0) begin
                            pc_d    = stk_q[top_idx];
                            depth_d = depth_q - 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.call && bus.twoByte) begin
                        pc_d = target;
                        if (depth_q == 3'd4) begin
                            for (int i = 0; i < 3; i++) begin
                                stk_d[i] = stk_q[i+1];
                            end
                            stk_d[3] = pc_inc;
                            err_d    = 1'b1;
                        end else begin
                            stk_d[depth_q[1:0]] = pc_inc;
                            depth_d = depth_q + 3'd1;
                        end
                    end else if (bus.jumpTaken && bus.twoByte) begin
                        pc_d = target;
                    end else if (bus.twoByte) begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                phase_d = PH_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= 12'h000;
            phase_q <= PH_FETCH;
            depth_q <= 3'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stk_q[i] <= 12'h000;
            end
        end else begin
            pc_q    <= pc_d;
            phase_q <= phase_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            stk_q   <= stk_d;
        end
    end

    assign bus.stackDepth = depth_q;
    assign bus.stackErr   = err_q;
`else
    // Without a stack, call degenerates to a jump and ret to a no-op
    always_comb begin
        pc_d    = pc_q;
        phase_d = phase_q;
        unique case (phase_q)
            PH_FETCH: begin
                pc_d    = pc_inc;
                phase_d = PH_EXEC;
            end
            PH_EXEC: begin
                if (!bus.halt) begin
                    phase_d = PH_FETCH;
                    if (bus.ret) begin
                        pc_d = pc_q;
                    end else if ((bus.call || bus.jumpTaken) && bus.twoByte) begin
                        pc_d = target;
                    end else if (bus.twoByte) begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                phase_d = PH_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= 12'h000;
            phase_q <= PH_FETCH;
        end else begin
            pc_q    <= pc_d;
            phase_q <= phase_d;
        end
    end

    assign bus.stackDepth = 3'd0;
    assign bus.stackErr   = 1'b0;
`endif

    assign bus.pc    = pc_q;
    assign bus.phase = phase_q;
endmodule
